// File: rtl/uart_pkg.sv
// Shared types and frame helpers for the UART transmit path (and the future RX path).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Line bits per frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-visible read data; push is dropped when full,
// even if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a local FIFO; frames are sent back-to-back while data is queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 217,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_e,
    output logic                        i_r,
    input  logic [DATA_BITS-1:0]        i_d,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_busy,
    output logic                        tx
);

    localparam int          FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam logic [15:0] DIV_M1     = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP  = 4'(STOP_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
        $error("uart_tx_fifo: CLK_DIV out of range");
    end
    if (FRAME_BITS < 7 || FRAME_BITS > 13 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_frame
        $error("uart_tx_fifo: illegal frame format");
    end
    if (PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
        $error("uart_tx_fifo: illegal parity or stop bits");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_t          state;
    logic [15:0]          timer;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 pop;

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~(^d) : ^d;
    endfunction

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_e),
        .pop   (pop),
        .wdata (i_d),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_level)
    );

    assign i_r     = !fifo_full;
    assign bit_end = (timer == 16'd0);

    // A new frame loads either from idle or on the very edge the last stop bit ends,
    // which is what keeps queued frames gap-free.
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) ||
                  (state == ST_STOP && bit_end && bit_cnt == LAST_STOP));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            o_busy  <= 1'b0;
            tx      <= 1'b1;
            timer   <= 16'd0;
            bit_cnt <= 4'd0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (pop) begin
            state   <= ST_START;
            o_busy  <= 1'b1;
            tx      <= 1'b0;
            timer   <= DIV_M1;
            bit_cnt <= 4'd0;
            shreg   <= head;
            par_bit <= par_of(head);
        end else if (state != ST_IDLE) begin
            if (!bit_end) begin
                timer <= timer - 16'd1;
            end else begin
                timer <= DIV_M1;
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= 4'd0;
                    end
                    ST_DATA: begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= 4'd0;
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    ST_PARITY: begin
                        state   <= ST_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= 4'd0;
                    end
                    ST_STOP: begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= ST_IDLE;
                            o_busy  <= 1'b0;
                            tx      <= 1'b1;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                        tx     <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats, line levels checked against a frame model.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // A: 8N1, depth 4
    logic       a_e = 1'b0, a_r, a_busy, a_tx;
    logic [7:0] a_d = '0;
    logic [2:0] a_lvl;
    // B: 8E2, C: 8O2
    logic       b_e = 1'b0, b_r, b_busy, b_tx;
    logic [7:0] b_d = '0;
    logic [2:0] b_lvl;
    logic       c_e = 1'b0, c_r, c_busy, c_tx;
    logic [7:0] c_d = '0;
    logic [2:0] c_lvl;
    // D: 5N1, CLK_DIV 2, depth 2
    logic       d_e = 1'b0, d_r, d_busy, d_tx;
    logic [4:0] d_d = '0;
    logic [1:0] d_lvl;

    logic [7:0] bw [6];

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .i_e(a_e), .i_r(a_r), .i_d(a_d),
        .o_level(a_lvl), .o_busy(a_busy), .tx(a_tx));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .i_e(b_e), .i_r(b_r), .i_d(b_d),
        .o_level(b_lvl), .o_busy(b_busy), .tx(b_tx));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .i_e(c_e), .i_r(c_r), .i_d(c_d),
        .o_level(c_lvl), .o_busy(c_busy), .tx(c_tx));
    uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(2)) u_d (
        .clk(clk), .rst(rst), .i_e(d_e), .i_r(d_r), .i_d(d_d),
        .o_level(d_lvl), .o_busy(d_busy), .tx(d_tx));

    // Level of line bit idx within a frame of word w; anything past the frame is idle high.
    function automatic logic exp_bit(input int w, input int db, input int par, input int idx);
        int ones;
        ones = $countones(w & ((1 << db) - 1));
        if (idx == 0) return 1'b0;
        if (idx <= db) return 1'((w >> (idx - 1)) & 1);
        if (par != 0 && idx == db + 1) return (par == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_lvl !== 3'd0 || a_r !== 1'b1) begin
            bad++;
            $display("FAIL reset_a tx=%b busy=%b lvl=%0d r=%b need 1 0 0 1", a_tx, a_busy, a_lvl, a_r);
        end
        total++;
        if (b_tx !== 1'b1 || c_tx !== 1'b1 || d_tx !== 1'b1 || b_busy !== 1'b0 ||
            c_busy !== 1'b0 || d_busy !== 1'b0 || d_lvl !== 2'd0 || d_r !== 1'b1) begin
            bad++;
            $display("FAIL reset_bcd tx=%b%b%b busy=%b%b%b dlvl=%0d dr=%b need tx=111 busy=000 0 1",
                     b_tx, c_tx, d_tx, b_busy, c_busy, d_busy, d_lvl, d_r);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8n1(input logic [7:0] w);
        int L = 40;
        int mism = 0, first = -1, busy_n = 0;
        a_e = 1'b1; a_d = w;
        @(negedge clk);
        a_e = 1'b0;
        total++;
        if (a_tx !== 1'b1 || a_lvl !== 3'd1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL 8n1_latency w=%h tx=%b lvl=%0d busy=%b need tx=1 lvl=1 busy=0", w, a_tx, a_lvl, a_busy);
        end
        for (int c = 0; c < L; c++) begin
            @(negedge clk);
            if (a_busy === 1'b1) busy_n++;
            if (a_tx !== exp_bit(int'(w), 8, 0, c / 4)) begin
                mism++;
                if (first < 0) first = c;
            end
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL 8n1_frame w=%h %0d bad cycles, first at %0d, need 0", w, mism, first);
        end
        total++;
        if (busy_n != L) begin
            bad++;
            $display("FAIL 8n1_busy w=%h busy cycles=%0d need %0d", w, busy_n, L);
        end
        @(negedge clk);
        total++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL 8n1_after w=%h tx=%b busy=%b need 1 0", w, a_tx, a_busy);
        end
    endtask

    task automatic test_parity(input logic [7:0] w);
        int L = 48;
        int mb = 0, mc = 0, busy_n = 0;
        b_e = 1'b1; c_e = 1'b1; b_d = w; c_d = w;
        @(negedge clk);
        b_e = 1'b0; c_e = 1'b0;
        for (int c = 0; c < L; c++) begin
            @(negedge clk);
            if (b_busy === 1'b1) busy_n++;
            if (b_tx !== exp_bit(int'(w), 8, 2, c / 4)) mb++;
            if (c_tx !== exp_bit(int'(w), 8, 1, c / 4)) mc++;
        end
        total++;
        if (mb != 0) begin
            bad++;
            $display("FAIL even2_frame w=%h %0d bad cycles need 0", w, mb);
        end
        total++;
        if (mc != 0) begin
            bad++;
            $display("FAIL odd2_frame w=%h %0d bad cycles need 0", w, mc);
        end
        @(negedge clk);
        total++;
        if (busy_n != L || b_busy !== 1'b0 || c_busy !== 1'b0 || b_tx !== 1'b1 || c_tx !== 1'b1) begin
            bad++;
            $display("FAIL parity_len w=%h busy cycles=%0d need %0d, end busy=%b%b tx=%b%b need 00 11",
                     w, busy_n, L, b_busy, c_busy, b_tx, c_tx);
        end
    endtask

    task automatic test_5bit(input logic [4:0] w);
        int L = 14;
        int mism = 0, busy_n = 0;
        d_e = 1'b1; d_d = w;
        @(negedge clk);
        d_e = 1'b0;
        for (int c = 0; c < L; c++) begin
            @(negedge clk);
            if (d_busy === 1'b1) busy_n++;
            if (d_tx !== exp_bit(int'(w), 5, 0, c / 2)) mism++;
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL 5n1_frame w=%h %0d bad cycles need 0", w, mism);
        end
        @(negedge clk);
        total++;
        if (busy_n != L || d_busy !== 1'b0 || d_tx !== 1'b1) begin
            bad++;
            $display("FAIL 5n1_len w=%h busy cycles=%0d need %0d, end busy=%b tx=%b need 0 1",
                     w, busy_n, L, d_busy, d_tx);
        end
    endtask

    // Six words pushed with i_e held high; frame j owns cycles 1+j*40 .. 40+j*40.
    task automatic test_back_to_back();
        int L = 40;
        int idx, acc = 0, acc_next, pops, exp_lvl;
        int lvl_bad = 0, rdy_bad = 0, tx_bad = 0, first = -1;
        bit saw_full = 1'b0;
        logic r40 = 1'b1;
        a_e = 1'b1; a_d = bw[0]; idx = 1; acc_next = 1;
        for (int k = 0; k <= 6 * L + 1; k++) begin
            @(negedge clk);
            acc = acc_next;
            pops = (k == 0) ? 0 : (k - 1) / L + 1;
            if (pops > 6) pops = 6;
            exp_lvl = acc - pops;
            if (a_lvl !== 3'(exp_lvl)) begin
                lvl_bad++;
                if (first < 0) first = k;
            end
            if (a_r !== (exp_lvl != 4)) rdy_bad++;
            if (exp_lvl == 4) saw_full = 1'b1;
            if (k >= 1 && k <= 6 * L) begin
                if (a_tx !== exp_bit(int'(bw[(k - 1) / L]), 8, 0, ((k - 1) % L) / 4)) tx_bad++;
            end
            if (k == 40) r40 = a_r;
            if (k == 41) begin
                total++;
                if (r40 !== 1'b0 || a_lvl !== 3'd3 || a_r !== 1'b1) begin
                    bad++;
                    $display("FAIL full_pop_push r_before=%b lvl=%0d r=%b need 0 3 1", r40, a_lvl, a_r);
                end
            end
            if (k == 6 * L + 1) begin
                total++;
                if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL burst_end tx=%b busy=%b need 1 0", a_tx, a_busy);
                end
            end
            if (idx < 6) begin
                a_e = 1'b1; a_d = bw[idx];
                if (a_r) begin
                    idx++;
                    acc_next++;
                end
            end else begin
                a_e = 1'b0;
            end
        end
        a_e = 1'b0;
        total++;
        if (lvl_bad != 0) begin
            bad++;
            $display("FAIL burst_level %0d bad cycles, first at %0d, need 0", lvl_bad, first);
        end
        total++;
        if (rdy_bad != 0 || !saw_full) begin
            bad++;
            $display("FAIL burst_ready %0d bad cycles, saw_full=%b need 0 1", rdy_bad, saw_full);
        end
        total++;
        if (tx_bad != 0 || idx != 6) begin
            bad++;
            $display("FAIL burst_line %0d bad cycles, pushed=%0d need 0 6", tx_bad, idx);
        end
    endtask

    task automatic test_reset_mid_frame();
        int idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            a_e = 1'b1; a_d = 8'($urandom);
            @(negedge clk);
        end
        a_e = 1'b0;
        repeat (13) @(negedge clk);
        total++;
        if (a_lvl !== 3'd3 || a_busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset lvl=%0d busy=%b need 3 1", a_lvl, a_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (a_tx !== 1'b1 || a_lvl !== 3'd0 || a_busy !== 1'b0 || a_r !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset tx=%b lvl=%0d busy=%b r=%b need 1 0 0 1", a_tx, a_lvl, a_busy, a_r);
        end
        repeat (200) begin
            @(negedge clk);
            if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_lvl !== 3'd0) idle_bad++;
        end
        total++;
        if (idle_bad != 0) begin
            bad++;
            $display("FAIL post_reset_idle %0d active cycles need 0", idle_bad);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1(8'h55);
        repeat (3) test_8n1(8'($urandom));
        test_parity(8'hA3);
        repeat (2) test_parity(8'($urandom));
        test_5bit(5'h1F);
        repeat (2) test_5bit(5'($urandom));
        for (int i = 0; i < 6; i++) bw[i] = 8'(i + 1);
        test_back_to_back();
        for (int i = 0; i < 6; i++) bw[i] = 8'($urandom);
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
